// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

  // Sequential successor; wraps naturally at 32 bits.
  function automatic logic [31:0] fetch_next_pc(input logic [31:0] pc);
    return pc + FETCH_PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} holding buffer used while decode is stalled.
// Latency: a load is visible on the outputs the cycle after i_load.
// Backpressure: none; the caller never loads while the entry is occupied.
//
// Ports: clk/reset (async active-low); i_load captures i_instr/i_pc;
// i_unload and i_flush both empty the entry; o_valid/o_instr/o_pc show it.
module fetch_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload || i_flush) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns PC, fetches words, fills the IF/ID slot.
// Latency: grant at N, rvalid at N+k, if_valid at N+k+1 (1 instr / 2 cycles peak).
// Backpressure: stall_d holds the slot; one response is parked in a skid entry.
//
// Ports: clk, reset (async active-low); im_req/im_addr/im_gnt request side,
// im_rvalid/im_rdata response side; stall_d and redir_valid/redir_pc from
// decode; if_valid/if_instr/if_pc/if_pc4 are the IF/ID slot.
// Build option: FETCH_DELAY_SLOT_EN keeps the instruction after a redirecting
// branch; without it every wrong-path fetch is squashed.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  input  logic        stall_d,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_req_pc, w_req_pc_nxt;
  logic         r_kill, w_kill_nxt;
  logic         r_if_valid;
  logic [31:0]  r_if_instr, r_if_pc;
`ifdef FETCH_DELAY_SLOT_EN
  logic         r_pend_valid, w_pend_valid_nxt;
  logic [31:0]  r_pend_pc, w_pend_pc_nxt;
`endif

  logic         w_redir;
  logic         w_drop;
  logic         w_slot_load;
  logic [31:0]  w_slot_instr, w_slot_pc;
  logic         w_skid_load, w_skid_unload, w_skid_flush;
  logic         w_skid_valid;
  logic [31:0]  w_skid_instr, w_skid_pc;

  // Decode only presents a redirect it has computed in an unstalled cycle.
  assign w_redir = redir_valid && !stall_d && (r_state != IDLE);

  fetch_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_flush  (w_skid_flush),
    .i_instr  (im_rdata),
    .i_pc     (r_req_pc),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_req_pc_nxt  = r_req_pc;
    w_kill_nxt    = r_kill;
    w_drop        = 1'b0;
    w_slot_load   = 1'b0;
    w_slot_instr  = im_rdata;
    w_slot_pc     = r_req_pc;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_flush  = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
`endif
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        if (im_gnt) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = fetch_next_pc(r_pc);
          w_state_nxt  = WAIT;
`ifdef FETCH_DELAY_SLOT_EN
          // The granted fetch is the delay slot; the target follows it.
          if (w_redir) w_pc_nxt = redir_pc;
          else if (r_pend_valid) w_pc_nxt = r_pend_pc;
          w_pend_valid_nxt = 1'b0;
`else
          if (w_redir) begin
            w_pc_nxt   = redir_pc;
            w_kill_nxt = 1'b1;
          end
`endif
        end else if (w_redir) begin
`ifdef FETCH_DELAY_SLOT_EN
          // Delay slot not yet fetched: park the target until the grant.
          w_pend_valid_nxt = 1'b1;
          w_pend_pc_nxt    = redir_pc;
`else
          w_pc_nxt = redir_pc;
`endif
        end
      end
      WAIT: begin
`ifdef FETCH_DELAY_SLOT_EN
        if (w_redir) w_pc_nxt = redir_pc;
        w_drop = r_kill;
`else
        if (w_redir) begin
          w_pc_nxt   = redir_pc;
          w_kill_nxt = 1'b1;
        end
        // A response coinciding with the redirect is wrong-path too.
        w_drop = r_kill || w_redir;
`endif
        if (im_rvalid) begin
          w_state_nxt = REQ;
          if (w_drop) begin
            w_kill_nxt = 1'b0;
          end else if (!r_if_valid || !stall_d) begin
            w_slot_load = 1'b1;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_d) begin
          w_state_nxt  = REQ;
          w_slot_instr = w_skid_instr;
          w_slot_pc    = w_skid_pc;
`ifdef FETCH_DELAY_SLOT_EN
          if (w_redir) w_pc_nxt = redir_pc;
          w_slot_load   = w_skid_valid;
          w_skid_unload = 1'b1;
`else
          if (w_redir) begin
            w_pc_nxt     = redir_pc;
            w_skid_flush = 1'b1;
          end else begin
            w_slot_load   = w_skid_valid;
            w_skid_unload = 1'b1;
          end
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_kill     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
`ifdef FETCH_DELAY_SLOT_EN
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_kill   <= w_kill_nxt;
`ifdef FETCH_DELAY_SLOT_EN
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
`endif
      // Instr/pc keep their last values when the slot drains.
      if (w_slot_load) begin
        r_if_valid <= 1'b1;
        r_if_instr <= w_slot_instr;
        r_if_pc    <= w_slot_pc;
      end else if (!stall_d) begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign im_req   = (r_state == REQ);
  assign im_addr  = r_pc;
  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;
  assign if_pc4   = fetch_next_pc(r_if_pc);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq with a one-outstanding memory responder.
// Inputs change 1 time unit after a falling edge; outputs are read there too.
// Instruction word returned for address A is A | 32'hA000_0000.
module tb_fetch_seq;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        stall_d;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int n_chk;
  int n_fail;

  // Responder controls (written by tests) and state (written by responder).
  logic        gnt_en;
  int          rsp_lat;
  logic        rsp_flush;
  logic        outst;
  int          o_cnt;
  logic [31:0] o_addr;

  fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_gnt      (im_gnt),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .stall_d     (stall_d),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: grants whenever enabled and idle, answers rsp_lat cycles later.
  initial begin
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0;
    outst = 1'b0; o_cnt = 0; o_addr = '0;
    forever begin
      @(negedge clk);
      im_rvalid = 1'b0;
      if (rsp_flush) begin
        outst = 1'b0;
      end else if (outst) begin
        o_cnt = o_cnt - 1;
        if (o_cnt == 0) begin
          im_rvalid = 1'b1;
          im_rdata  = o_addr | 32'hA000_0000;
          outst     = 1'b0;
        end
      end
      im_gnt = 1'b0;
      if (im_req && gnt_en && !outst) begin
        im_gnt = 1'b1;
        outst  = 1'b1;
        o_addr = im_addr;
        o_cnt  = rsp_lat;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; rsp_flush = 1'b1;
    stall_d = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    nxt(2);
    reset = 1'b1; rsp_flush = 1'b0;
  endtask

  task automatic test_reset();
    gnt_en = 1'b1; rsp_lat = 1;
    reset = 1'b0; rsp_flush = 1'b1;
    stall_d = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    nxt(2);
    n_chk++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", im_req); end
    n_chk++; if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_addr: got %h want 00003000", im_addr); end
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", if_valid); end
    n_chk++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    n_chk++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    n_chk++; if (if_pc4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h want 4", if_pc4); end
    reset = 1'b1; rsp_flush = 1'b0;
    #1;
    n_chk++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %0b want 0", im_req); end
    nxt(1);
    n_chk++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %0b want 1", im_req); end
    n_chk++; if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL first_addr: got %h want 00003000", im_addr); end
  endtask

  task automatic test_basic();
    gnt_en = 1'b1; rsp_lat = 1;
    do_reset();
    nxt(3);
    n_chk++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL bas_v0: got %0b want 1", if_valid); end
    n_chk++; if (if_pc !== 32'h3000) begin n_fail++; $display("FAIL bas_pc0: got %h want 00003000", if_pc); end
    n_chk++; if (if_instr !== 32'hA000_3000) begin n_fail++; $display("FAIL bas_in0: got %h want a0003000", if_instr); end
    n_chk++; if (if_pc4 !== 32'h3004) begin n_fail++; $display("FAIL bas_pc4: got %h want 00003004", if_pc4); end
    n_chk++; if (im_addr !== 32'h3004 || im_req !== 1'b1) begin n_fail++; $display("FAIL bas_req1: got %0b/%h want 1/00003004", im_req, im_addr); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin n_fail++; $display("FAIL bas_gap: got %0b/%0b want 0/0", if_valid, im_req); end
    nxt(1);
    n_chk++; if (if_pc !== 32'h3004 || if_instr !== 32'hA000_3004) begin n_fail++; $display("FAIL bas_pc1: got %h/%h want 00003004/a0003004", if_pc, if_instr); end
    n_chk++; if (im_addr !== 32'h3008) begin n_fail++; $display("FAIL bas_req2: got %h want 00003008", im_addr); end
    nxt(2);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3008) begin n_fail++; $display("FAIL bas_pc2: got %0b/%h want 1/00003008", if_valid, if_pc); end
    n_chk++; if (if_pc4 !== 32'h300C) begin n_fail++; $display("FAIL bas_pc4b: got %h want 0000300c", if_pc4); end
  endtask

  task automatic test_stall();
    gnt_en = 1'b1; rsp_lat = 1;
    do_reset();
    nxt(3);
    n_chk++; if (if_pc !== 32'h3000) begin n_fail++; $display("FAIL stl_pc0: got %h want 00003000", if_pc); end
    stall_d = 1'b1;
    nxt(1);
    n_chk++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL stl_wait: got %0b want 0", im_req); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3000) begin n_fail++; $display("FAIL stl_hold: got %0b/%h want 1/00003000", if_valid, if_pc); end
    for (int i = 0; i < 3; i++) begin
      nxt(1);
      n_chk++; if (im_req !== 1'b0 || if_pc !== 32'h3000) begin n_fail++; $display("FAIL stl_keep%0d: got %0b/%h want 0/00003000", i, im_req, if_pc); end
    end
    stall_d = 1'b0;
    nxt(1);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3004 || if_instr !== 32'hA000_3004) begin n_fail++; $display("FAIL stl_skid: got %0b/%h/%h want 1/00003004/a0003004", if_valid, if_pc, if_instr); end
    n_chk++; if (im_req !== 1'b1 || im_addr !== 32'h3008) begin n_fail++; $display("FAIL stl_req: got %0b/%h want 1/00003008", im_req, im_addr); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stl_drain: got %0b want 0", if_valid); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3008) begin n_fail++; $display("FAIL stl_next: got %0b/%h want 1/00003008", if_valid, if_pc); end
  endtask

  // Redirect while the 0x3008 response is still three cycles away.
  task automatic test_redirect();
    gnt_en = 1'b1; rsp_lat = 1;
    do_reset();
    nxt(4);
    rsp_lat = 3;
    nxt(2);
    redir_valid = 1'b1; redir_pc = 32'h3100;
    nxt(1);
    redir_valid = 1'b0; rsp_lat = 1;
    n_chk++; if (im_req !== 1'b0 || im_addr !== 32'h3100) begin n_fail++; $display("FAIL rdw_pc: got %0b/%h want 0/00003100", im_req, im_addr); end
    n_chk++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_v0: got %0b want 0", if_valid); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin n_fail++; $display("FAIL rdw_v1: got %0b/%0b want 0/0", if_valid, im_req); end
    nxt(1);
    n_chk++; if (im_req !== 1'b1 || im_addr !== 32'h3100) begin n_fail++; $display("FAIL rdw_req: got %0b/%h want 1/00003100", im_req, im_addr); end
    n_chk++; if (if_valid !== DS) begin n_fail++; $display("FAIL rdw_ds: got %0b want %0b", if_valid, DS); end
    n_chk++; if (if_pc !== (DS ? 32'h3008 : 32'h3004)) begin n_fail++; $display("FAIL rdw_dspc: got %h want %h", if_pc, (DS ? 32'h3008 : 32'h3004)); end
    nxt(2);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3100 || if_instr !== 32'hA000_3100) begin n_fail++; $display("FAIL rdw_tgt: got %0b/%h/%h want 1/00003100/a0003100", if_valid, if_pc, if_instr); end
  endtask

  // Redirect in the same cycle as the 0x3008 response.
  task automatic test_redirect_same();
    gnt_en = 1'b1; rsp_lat = 1;
    do_reset();
    nxt(6);
    redir_valid = 1'b1; redir_pc = 32'h3100;
    nxt(1);
    redir_valid = 1'b0;
    n_chk++; if (im_req !== 1'b1 || im_addr !== 32'h3100) begin n_fail++; $display("FAIL rds_req: got %0b/%h want 1/00003100", im_req, im_addr); end
    n_chk++; if (if_valid !== DS) begin n_fail++; $display("FAIL rds_v: got %0b want %0b", if_valid, DS); end
    n_chk++; if (if_pc !== (DS ? 32'h3008 : 32'h3004)) begin n_fail++; $display("FAIL rds_pc: got %h want %h", if_pc, (DS ? 32'h3008 : 32'h3004)); end
    nxt(2);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3100) begin n_fail++; $display("FAIL rds_tgt: got %0b/%h want 1/00003100", if_valid, if_pc); end
  endtask

  task automatic test_redirect_stalled();
    gnt_en = 1'b1; rsp_lat = 1;
    do_reset();
    nxt(3);
    stall_d = 1'b1; redir_valid = 1'b1; redir_pc = 32'h3100;
    nxt(2);
    n_chk++; if (im_req !== 1'b0 || im_addr !== 32'h3008) begin n_fail++; $display("FAIL rst_ign: got %0b/%h want 0/00003008", im_req, im_addr); end
    n_chk++; if (if_pc !== 32'h3000) begin n_fail++; $display("FAIL rst_slot: got %h want 00003000", if_pc); end
    stall_d = 1'b0; redir_valid = 1'b0;
    nxt(1);
    n_chk++; if (if_pc !== 32'h3004 || im_req !== 1'b1 || im_addr !== 32'h3008) begin n_fail++; $display("FAIL rst_go: got %h/%0b/%h want 00003004/1/00003008", if_pc, im_req, im_addr); end
  endtask

  // Redirect in REQ with the grant held off; target exercises the pc wrap.
  task automatic test_redirect_req();
    logic [31:0] hold_addr;
    hold_addr = DS ? 32'h3000 : 32'hFFFF_FFFC;
    gnt_en = 1'b0; rsp_lat = 1;
    do_reset();
    nxt(1);
    redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      nxt(1);
      redir_valid = 1'b0;
      n_chk++; if (im_req !== 1'b1 || im_addr !== hold_addr) begin n_fail++; $display("FAIL rrq_hold%0d: got %0b/%h want 1/%h", i, im_req, im_addr, hold_addr); end
    end
    gnt_en = 1'b1;
    nxt(1);
    n_chk++; if (im_addr !== hold_addr) begin n_fail++; $display("FAIL rrq_gnt: got %h want %h", im_addr, hold_addr); end
    nxt(1);
    n_chk++; if (im_req !== 1'b0 || im_addr !== (DS ? 32'hFFFF_FFFC : 32'h0)) begin n_fail++; $display("FAIL rrq_sw: got %0b/%h want 0/%h", im_req, im_addr, (DS ? 32'hFFFF_FFFC : 32'h0)); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== hold_addr) begin n_fail++; $display("FAIL rrq_slot: got %0b/%h want 1/%h", if_valid, if_pc, hold_addr); end
    n_chk++; if (if_pc4 !== (DS ? 32'h3004 : 32'h0)) begin n_fail++; $display("FAIL rrq_pc4: got %h want %h", if_pc4, (DS ? 32'h3004 : 32'h0)); end
    nxt(2);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== (DS ? 32'hFFFF_FFFC : 32'h0)) begin n_fail++; $display("FAIL rrq_nxt: got %0b/%h want 1/%h", if_valid, if_pc, (DS ? 32'hFFFF_FFFC : 32'h0)); end
    n_chk++; if (if_pc4 !== (DS ? 32'h0 : 32'h4)) begin n_fail++; $display("FAIL rrq_wrap: got %h want %h", if_pc4, (DS ? 32'h0 : 32'h4)); end
  endtask

  task automatic test_reset_mid();
    gnt_en = 1'b1; rsp_lat = 1;
    do_reset();
    nxt(1);
    rsp_lat = 3;
    nxt(3);
    reset = 1'b0; rsp_lat = 1;
    #1;
    n_chk++; if (im_req !== 1'b0 || im_addr !== 32'h3000) begin n_fail++; $display("FAIL rmw_req: got %0b/%h want 0/00003000", im_req, im_addr); end
    n_chk++; if (if_valid !== 1'b0 || if_pc !== 32'h0) begin n_fail++; $display("FAIL rmw_slot: got %0b/%h want 0/0", if_valid, if_pc); end
    nxt(1);
    reset = 1'b1;
    nxt(1);
    n_chk++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin n_fail++; $display("FAIL rmw_re: got %0b/%h want 1/00003000", im_req, im_addr); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b0 || im_req !== 1'b0) begin n_fail++; $display("FAIL rmw_late: got %0b/%0b want 0/0", if_valid, im_req); end
    nxt(1);
    n_chk++; if (if_valid !== 1'b1 || if_pc !== 32'h3000 || if_instr !== 32'hA000_3000) begin n_fail++; $display("FAIL rmw_fet: got %0b/%h/%h want 1/00003000/a0003000", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0; rsp_flush = 1'b1; gnt_en = 1'b1; rsp_lat = 1;
    stall_d = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_redirect_same();
    test_redirect_stalled();
    test_redirect_req();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer for the five-stage MIPS pipeline. It owns the PC register and issues word fetches to instruction memory over a request/grant/response handshake. It fills the IF/ID slot with `{instr, pc}` and honours decode-stage stalls. It applies branch/jump redirects produced by the decode-stage next-PC calculation, with or without an architectural delay slot.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `im_req`  out  1  fetch request valid
- `im_addr`  out  32  fetch address, equals PC register
- `im_gnt`  in  1  memory accepts request this cycle (only meaningful with `im_req`)
- `im_rvalid`  in  1  response data valid, earliest one cycle after grant
- `im_rdata`  in  32  instruction word
- `stall_d`  in  1  decode stalled; IF/ID slot must hold
- `redir_valid`  in  1  redirect from decode; sampled only when `stall_d`=0
- `redir_pc`  in  32  redirect target
- `if_valid`  out  1  IF/ID slot holds a valid instruction
- `if_instr`  out  32  IF/ID instruction
- `if_pc`  out  32  IF/ID instruction address
- `if_pc4`  out  32  `if_pc`+4, combinational

## Operation
- State machine: IDLE, REQ, WAIT, HOLD. Reset enters IDLE. IDLE→REQ unconditionally on the next cycle.
- REQ: `im_req`=1, `im_addr`=pc.
  - On `im_gnt`: latch `req_pc`=pc, set pc ← next (see below), go WAIT.
  - `im_addr` may change before the grant. Address stability is required only in the grant cycle.
- WAIT: `im_req`=0. On `im_rvalid`:
  - If `kill`=1: drop the data, clear `kill`, go REQ.
  - Else if `if_valid`=0 or `stall_d`=0: load the slot `{im_rdata, req_pc}`, go REQ.
  - Else: store into the one-entry skid buffer, go HOLD.
- HOLD: `im_req`=0. When `stall_d`=0, move the skid buffer into the slot and go REQ.
- Slot drain: when `stall_d`=0 and no load occurs, clear `if_valid`. `if_instr` and `if_pc` keep their last values.
- Sequential next pc is pc+4, with 32-bit wrap (0xFFFF_FFFC+4 = 0).
- At most one request is outstanding. The pc register's low 2 bits pass through unchecked; alignment is the decoder's responsibility.
- Redirects are accepted only when `redir_valid`=1 and `stall_d`=0. Redirects under stall or in IDLE are ignored, and the source must hold them. Redirect handling is governed by `DELAY_SLOT_EN` (see Configuration).

## Timing
- Reset values: `im_req`=0, `im_addr`=RESET_PC, pc=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `kill`=0, `pend_valid`=0.
- First `im_req` is asserted in the 2nd cycle after reset deassertion.
- Latency: grant at cycle N, rvalid at N+k (k≥1), `if_valid` at N+k+1.
- Peak throughput is one instruction per 2 cycles with single-cycle grant and response.
- Reset mid-transaction:
  - An in-flight response is discarded.
  - The memory side must tolerate a late `im_rvalid` arriving in IDLE/REQ. It is ignored there.
- `im_rvalid` outside WAIT is ignored.

## Configuration
- `FETCH_DELAY_SLOT_EN` defined: the instruction sequentially after the redirecting branch (the delay slot) is kept, and the target is fetched after it.
  - HOLD: the skid moves to the slot; pc ← `redir_pc`.
  - WAIT: the in-flight response is kept; pc ← `redir_pc`.
  - REQ with grant in the same cycle: the granted fetch is the delay slot; pc ← `redir_pc`.
  - REQ without grant: latch `pend_pc`/`pend_valid`. On a later grant, pc ← `pend_pc` and `pend_valid` is cleared.
- Undefined: no delay slot; all wrong-path work is squashed.
  - HOLD: the skid is dropped; go REQ with pc ← `redir_pc`.
  - WAIT: set `kill`, including when `im_rvalid` arrives in the same cycle, so that response is also dropped; pc ← `redir_pc`.
  - REQ without grant: pc ← `redir_pc`.
  - REQ with grant: set `kill`, go WAIT, pc ← `redir_pc`.
  - In every case `if_valid` is 0 the cycle after the redirect.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, REQ, WAIT, HOLD}
  - `FETCH_RESET_PC`=32'h0000_3000
  - `FETCH_PC_STEP`=4
- Sub-module `fetch_skid`: one-entry `{instr, pc}` buffer with load/unload/flush controls.

## Test plan
- Reset release, `im_gnt`=1 and 1-cycle response: addresses 0x3000, 0x3004, 0x3008 are issued. `if_pc` follows at 2-cycle spacing, with `if_pc4`=`if_pc`+4.
- `stall_d`=1 for 5 cycles while a response returns:
  - The response goes to the skid (HOLD) and the slot holds.
  - On release, the slot gets the skid entry; the next request issues 1 cycle later.
  - No instruction is lost or duplicated.
- Redirect to 0x3100 while WAITing for 0x3008, delay slot off: 0x3008 is dropped, the next request is 0x3100, and `if_valid`=0 in between.
- Same stimulus with `FETCH_DELAY_SLOT_EN`: 0x3008 reaches the slot, then 0x3100 is fetched.
- Redirect in REQ with `im_gnt`=0 for 3 cycles, delay slot on: `im_addr` stays at the delay-slot address until the grant, then switches to the target.
- Redirect with `stall_d`=1: ignored. Pulling reset mid-WAIT: `if_valid`=0, and the next request is 0x3000 with the late rvalid ignored.
